// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the two-source interrupt controller.
//   state_e       : request FSM encoding
//   CFG_*         : config register bit indices
//   STS_*         : status readback field positions
//   src_t         : source identifier (two sources -> one bit)
package int_ctrl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } state_e;

    localparam int SRC_W = 1;
    typedef logic [SRC_W-1:0] src_t;

    localparam int CFG_GIE    = 0;
    localparam int CFG_EN0    = 1;
    localparam int CFG_EN1    = 2;
    localparam int CFG_ERRCLR = 8;

    localparam int STS_GIE   = 0;
    localparam int STS_EN0   = 1;
    localparam int STS_EN1   = 2;
    localparam int STS_PEND0 = 3;
    localparam int STS_PEND1 = 4;
    localparam int STS_ISR0  = 5;
    localparam int STS_ISR1  = 6;
    localparam int STS_DEPTH = 7;   // two bits, [8:7]
    localparam int STS_ERR   = 9;

endpackage

// File: rtl/int_edge_detect.sv
// Rising-edge detector for one pre-synchronised interrupt pin.
//   CLK, Reset : clock and synchronous active-high reset
//   sig_i      : pin level
//   rise_o     : high for the cycle in which sig_i is 1 and was 0 last cycle
module int_edge_detect (
    input  logic CLK,
    input  logic Reset,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge CLK) begin
        if (Reset) prev_q <= 1'b0;
        else       prev_q <= sig_i;
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Two-source interrupt controller: edge-latched pending bits, enable mask,
// one-bit priority levels, request/acknowledge FSM and a 2-deep level stack
// tracking nested service routines.
//   CLK, Reset          : clock, synchronous active-high reset
//   int0, int1          : source request pins (rising-edge triggered)
//   intLvl0, intLvl1    : source priority levels (1 = high)
//   intWrite, intDataIn : config write ([0]GIE [1]EN0 [2]EN1, [8]=1 clears err)
//   intDataOut          : registered status readback
//   intAck, intRet      : core acknowledge / return-from-interrupt pulses
//   intr, intVec        : registered request and vector of last acknowledged source
//
// state     | meaning
// ST_IDLE   | no request to core; waiting for a qualified pending source
// ST_ASSERT | intr high for latched winner; waiting for intAck
module interrupt_controller
    import int_ctrl_pkg::*;
#(
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        int0,
    input  logic        int1,
    input  logic        intLvl0,
    input  logic        intLvl1,
    input  logic        intWrite,
    input  logic [15:0] intDataIn,
    output logic [15:0] intDataOut,
    input  logic        intAck,
    input  logic        intRet,
    output logic        intr,
    output logic [15:0] intVec
);

    state_e      state_q, state_d;
    src_t        win_q, win_d;
    logic [2:0]  cfg_q, cfg_d;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  isr_q, isr_d;
    logic [1:0]  depth_q, depth_d;
    logic [1:0]  stk_src_q, stk_lvl_q;
    logic        err_q, err_d;
    logic        intr_q;
    logic [15:0] vec_q, vec_d;
    logic [15:0] sts_q;

    logic [1:0]  rise, lvl, qual;
    logic        top_idx, top_lvl, pick, push, pop;

    int_edge_detect u_edge0 (.CLK(CLK), .Reset(Reset), .sig_i(int0), .rise_o(rise[0]));
    int_edge_detect u_edge1 (.CLK(CLK), .Reset(Reset), .sig_i(int1), .rise_o(rise[1]));

    always_comb begin
        lvl     = {intLvl1, intLvl0};
        top_idx = (depth_q == 2'd2);
        top_lvl = stk_lvl_q[top_idx];

        // A nested source must strictly outrank the routine currently running.
        qual[0] = cfg_q[CFG_GIE] & cfg_q[CFG_EN0] & pend_q[0] & ~isr_q[0]
                & ((depth_q == 2'd0) | (lvl[0] & ~top_lvl));
        qual[1] = cfg_q[CFG_GIE] & cfg_q[CFG_EN1] & pend_q[1] & ~isr_q[1]
                & ((depth_q == 2'd0) | (lvl[1] & ~top_lvl));
        // Source 1 only wins alone or with a strictly higher level.
        pick = qual[1] & (~qual[0] | (lvl[1] & ~lvl[0]));

        state_d = state_q;
        win_d   = win_q;
        push    = 1'b0;
        pop     = 1'b0;
        err_d   = err_q;
        vec_d   = vec_q;
        pend_d  = pend_q;
        isr_d   = isr_q;
        depth_d = depth_q;
        cfg_d   = cfg_q;

        case (state_q)
            ST_IDLE: begin
                if (|qual) begin
                    state_d = ST_ASSERT;
                    win_d   = pick;
                end
            end
            ST_ASSERT: begin
                if (!qual[win_q]) begin
                    state_d = ST_IDLE;
                end else if (intAck) begin
                    state_d = ST_IDLE;
                    push    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (intWrite) begin
            cfg_d = intDataIn[2:0];
            if (intDataIn[CFG_ERRCLR]) err_d = 1'b0;
        end

        if (intAck && !intr_q) err_d = 1'b1;
        if (intAck && intRet)  err_d = 1'b1;
        if (intRet && !intAck) begin
            if (depth_q == 2'd0) err_d = 1'b1;
            else                 pop   = 1'b1;
        end

        if (push) begin
            pend_d[win_q] = 1'b0;
            isr_d[win_q]  = 1'b1;
            depth_d       = depth_q + 2'd1;
            vec_d         = win_q ? (VEC_BASE + VEC_STRIDE) : VEC_BASE;
        end
        if (pop) begin
            isr_d[stk_src_q[top_idx]] = 1'b0;
            depth_d                   = depth_q - 2'd1;
        end
        // A new edge in the same cycle as the ack-clear keeps the source pending.
        pend_d = pend_d | rise;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            cfg_q     <= '0;
            pend_q    <= '0;
            isr_q     <= '0;
            depth_q   <= '0;
            stk_src_q <= '0;
            stk_lvl_q <= '0;
            err_q     <= 1'b0;
            intr_q    <= 1'b0;
            vec_q     <= VEC_BASE;
            sts_q     <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cfg_q   <= cfg_d;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            intr_q  <= (state_d == ST_ASSERT);
            vec_q   <= vec_d;
            if (push) begin
                stk_src_q[depth_q[0]] <= win_q;
                stk_lvl_q[depth_q[0]] <= lvl[win_q];
            end
            sts_q <= {6'b0, err_d, depth_d, isr_d, pend_d, cfg_d};
        end
    end

    assign intr       = intr_q;
    assign intVec     = vec_q;
    assign intDataOut = sts_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    logic        CLK = 1'b0;
    logic        Reset, int0, int1, intLvl0, intLvl1, intWrite, intAck, intRet;
    logic [15:0] intDataIn;
    logic [15:0] intDataOut, intVec;
    logic        intr;

    int vectors = 0;
    int miscompares = 0;

    interrupt_controller dut (
        .CLK(CLK), .Reset(Reset), .int0(int0), .int1(int1),
        .intLvl0(intLvl0), .intLvl1(intLvl1),
        .intWrite(intWrite), .intDataIn(intDataIn), .intDataOut(intDataOut),
        .intAck(intAck), .intRet(intRet), .intr(intr), .intVec(intVec)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] d);
        intWrite = 1'b1; intDataIn = d;
        step();
        intWrite = 1'b0; intDataIn = '0;
    endtask

    task automatic ack();
        intAck = 1'b1; step(); intAck = 1'b0;
    endtask

    task automatic ret();
        intRet = 1'b1; step(); intRet = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; int0 = 0; int1 = 0; intLvl0 = 0; intLvl1 = 0;
        intWrite = 0; intDataIn = '0; intAck = 0; intRet = 0;
        step(); step();
        Reset = 1'b0;
        chk("rst_intr", {15'b0, intr}, 16'h0000);
        chk("rst_vec", intVec, 16'h0040);
        chk("rst_sts", intDataOut, 16'h0000);

        // 1: single source, two-cycle edge-to-request latency, ack
        wr(16'h0007);
        chk("t1_cfg", intDataOut, 16'h0007);
        int0 = 1; step();
        chk("t1_pend_intr", {15'b0, intr}, 16'h0000);
        chk("t1_pend_sts", intDataOut, 16'h000F);
        step();
        chk("t1_intr", {15'b0, intr}, 16'h0001);
        ack();
        chk("t1_vec", intVec, 16'h0040);
        chk("t1_ack_intr", {15'b0, intr}, 16'h0000);
        chk("t1_ack_sts", intDataOut, 16'h00A7);
        int0 = 0; ret();
        chk("t1_ret_sts", intDataOut, 16'h0007);

        // 2: equal-level tie goes to source 0, source 1 waits for the return
        int0 = 1; int1 = 1; step();
        chk("t2_pend_sts", intDataOut, 16'h001F);
        step();
        chk("t2_intr", {15'b0, intr}, 16'h0001);
        int0 = 0; int1 = 0; ack();
        chk("t2_vec0", intVec, 16'h0040);
        chk("t2_ack_sts", intDataOut, 16'h00B7);
        step();
        chk("t2_no_nest", {15'b0, intr}, 16'h0000);
        ret();
        chk("t2_ret_sts", intDataOut, 16'h0017);
        step();
        chk("t2_intr1", {15'b0, intr}, 16'h0001);
        ack();
        chk("t2_vec1", intVec, 16'h0050);
        chk("t2_ack1_sts", intDataOut, 16'h00C7);
        ret();
        chk("t2_ret1_sts", intDataOut, 16'h0007);

        // 3: high-level source 1 preempts low-level source 0
        intLvl0 = 0; intLvl1 = 1;
        int0 = 1; step(); step();
        int0 = 0; ack();
        chk("t3_ack0_sts", intDataOut, 16'h00A7);
        int1 = 1; step();
        chk("t3_pend1_sts", intDataOut, 16'h00B7);
        step();
        chk("t3_preempt_intr", {15'b0, intr}, 16'h0001);
        int1 = 0; ack();
        chk("t3_vec", intVec, 16'h0050);
        chk("t3_depth2_sts", intDataOut, 16'h0167);
        ret();
        chk("t3_ret1_sts", intDataOut, 16'h00A7);
        ret();
        chk("t3_ret2_sts", intDataOut, 16'h0007);

        // 4: equal high level cannot nest
        intLvl0 = 1; intLvl1 = 1;
        int1 = 1; step(); step();
        int1 = 0; ack();
        chk("t4_ack1_sts", intDataOut, 16'h00C7);
        int0 = 1; step();
        chk("t4_pend0_sts", intDataOut, 16'h00CF);
        step();
        chk("t4_blocked_a", {15'b0, intr}, 16'h0000);
        step();
        chk("t4_blocked_b", {15'b0, intr}, 16'h0000);
        int0 = 0; ret();
        chk("t4_ret_sts", intDataOut, 16'h000F);
        step();
        chk("t4_intr0", {15'b0, intr}, 16'h0001);
        ack();
        chk("t4_vec", intVec, 16'h0040);
        chk("t4_ack0_sts", intDataOut, 16'h00A7);
        ret();
        chk("t4_ret0_sts", intDataOut, 16'h0007);

        // 5: protocol errors and error clear
        ret();
        chk("t5_ret_err", intDataOut, 16'h0207);
        ack();
        chk("t5_ack_err", intDataOut, 16'h0207);
        chk("t5_ack_intr", {15'b0, intr}, 16'h0000);
        wr(16'h0100);
        chk("t5_errclr", intDataOut, 16'h0000);

        // 6: disable while asserted, then reset mid-service
        wr(16'h0007);
        intLvl0 = 0; intLvl1 = 0;
        int0 = 1; step(); step();
        chk("t6_intr", {15'b0, intr}, 16'h0001);
        int0 = 0; wr(16'h0000);
        step();
        chk("t6_drop_intr", {15'b0, intr}, 16'h0000);
        chk("t6_pend_kept", intDataOut, 16'h0008);
        wr(16'h0007);
        step();
        chk("t6_reassert", {15'b0, intr}, 16'h0001);
        ack();
        chk("t6_isr_sts", intDataOut, 16'h00A7);
        Reset = 1'b1; step(); Reset = 1'b0;
        chk("t6_rst_sts", intDataOut, 16'h0000);
        chk("t6_rst_vec", intVec, 16'h0040);
        chk("t6_rst_intr", {15'b0, intr}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
